// File: rtl/gestor_interrupciones.sv
// -----------------------------------------------------------------------------
// gestor_interrupciones
//
// Interrupt aggregator in front of the KCPSM6 (PicoBlaze) wrapper. Four
// asynchronous event sources are synchronized, normalized to active-high,
// edge-detected and latched into pending bits. A software mask gates the
// pending bits into the micro's single interrupt line, which is managed by a
// small IDLE / ASSERT / SERVICE handshake driven by interrupt_ack and by
// writes to the clear register.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   irq_src[3:0]  raw event sources: [0] RTC irq (active-low), [1] keyboard,
//                 [2] audio end-of-note, [3] spare
//   port_id[7:0]  micro port address
//   in_data[7:0]  micro out_port data
//   write_strobe  micro write strobe (1 cycle)
//   read_strobe   micro read strobe (1 cycle); reads have no side effects
//   out_data[7:0] registered read data, 0 for ports not owned by this block
//   interrupt     to KCPSM6 interrupt input
//   interrupt_ack from KCPSM6, 1-cycle pulse
//
// Register map:
//   PORT_MASK (R/W) {4'b0, mask}
//   PORT_PEND (R)   {|active, 1'b0, idx[1:0], pending}
//   PORT_CLR  (W)   write-1-to-clear of pending and overrun
//   PORT_OVR  (R)   {4'b0, overrun}
// -----------------------------------------------------------------------------
module gestor_interrupciones #(
    parameter logic [7:0] PORT_MASK = 8'h30,
    parameter logic [7:0] PORT_PEND = 8'h31,
    parameter logic [7:0] PORT_CLR  = 8'h32,
    parameter logic [7:0] PORT_OVR  = 8'h33,
    parameter logic [3:0] POL_LOW   = 4'b0001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq_src,
    input  logic [7:0] port_id,
    input  logic [7:0] in_data,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] out_data,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Synchronizer chain; r_prev holds the previous raw synchronized level
    // so that, out of reset, current and previous agree for every source
    // regardless of polarity and no spurious edge is seen.
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_prev;

    logic [3:0] r_pending;
    logic [3:0] r_overrun;
    logic [3:0] r_mask;
    logic [7:0] r_out_data;
    state_t     r_state;

    logic [3:0] w_event;
    logic [3:0] w_clr;
    logic [3:0] w_pending_next;
    logic [3:0] w_overrun_next;
    logic [3:0] w_active;
    logic [1:0] w_idx;
    logic [7:0] w_rd_data;
    logic       w_wr_mask;
    logic       w_wr_clr;
    logic       w_interrupt;
    state_t     w_state_next;

    // Read strobe and the upper data bits carry no meaning for this block.
    logic       w_unused;
    assign w_unused = ^{read_strobe, in_data[7:4]};

    // -------------------------------------------------------------------------
    // Input conditioning
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 4'b0;
            r_sync2 <= 4'b0;
            r_prev  <= 4'b0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_edge
            // Rising edge of the polarity-normalized signal.
            assign w_event[gi] = (r_sync2[gi] ^ POL_LOW[gi]) &
                                 ~(r_prev[gi] ^ POL_LOW[gi]);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Register writes, pending and overrun
    // -------------------------------------------------------------------------
    assign w_wr_mask = write_strobe && (port_id == PORT_MASK);
    assign w_wr_clr  = write_strobe && (port_id == PORT_CLR);
    assign w_clr     = w_wr_clr ? in_data[3:0] : 4'b0;

    // An event wins over a same-cycle clear. Overrun only records an event on
    // a bit that stays pending, so a clear in the same cycle suppresses it.
    assign w_pending_next = w_event | (r_pending & ~w_clr);
    assign w_overrun_next = (r_overrun & ~w_clr) | (w_event & r_pending & ~w_clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 4'b0;
            r_overrun <= 4'b0;
            r_mask    <= 4'b0;
        end else begin
            r_pending <= w_pending_next;
            r_overrun <= w_overrun_next;
            if (w_wr_mask) begin
                r_mask <= in_data[3:0];
            end
        end
    end

    assign w_active = r_pending & r_mask;

    // Lowest-numbered active source; scanning downwards lets the lowest win.
    always_comb begin
        w_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_active[i]) begin
                w_idx = i[1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read mux, registered every cycle from port_id alone
    // -------------------------------------------------------------------------
    always_comb begin
        w_rd_data = 8'h00;
        case (port_id)
            PORT_MASK: w_rd_data = {4'b0, r_mask};
            PORT_PEND: w_rd_data = {|w_active, 1'b0, w_idx, r_pending};
            PORT_OVR:  w_rd_data = {4'b0, r_overrun};
            default:   w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data <= 8'h00;
        end else begin
            r_out_data <= w_rd_data;
        end
    end

    assign out_data = r_out_data;

    // -------------------------------------------------------------------------
    // Interrupt handshake FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|w_active) begin
                    w_state_next = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // Held until acknowledged, even if mask/clear remove the cause.
                if (interrupt_ack) begin
                    w_state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                // Any clear write ends the service window, whatever its data.
                if (w_wr_clr) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_interrupt = 1'b0;
        case (r_state)
            ST_ASSERT: w_interrupt = 1'b1;
            default:   w_interrupt = 1'b0;
        endcase
    end

    assign interrupt = w_interrupt;

endmodule

// File: doc/gestor_interrupciones.md
Name: gestor_interrupciones

Overview:
- Interrupt aggregator sitting directly upstream of the PicoBlaze (KCPSM6) wrapper; drives its `interrupt` input and consumes `interrupt_ack`.
- Collects four asynchronous event sources: RTC `irq` pin, keyboard scan-code-ready, audio end-of-note, and a spare.
- Latches each source's edges into pending bits and gates them with a software mask.
- Exposes mask, pending/cause and overrun registers on the micro's port_id / in / out port bus, alongside the RTC, keyboard, VGA and audio blocks.

Parameters:
- PORT_MASK, 8'h30, port_id of the mask register (R/W).
- PORT_PEND, 8'h31, port_id of the pending/cause register (R).
- PORT_CLR, 8'h32, port_id of the write-1-to-clear register (W).
- PORT_OVR, 8'h33, port_id of the overrun register (R).
- POL_LOW, 4'b0001, per-source polarity; 1 means active-low (the RTC irq is active-low).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq_src  in  4  raw event sources [0]=RTC irq, [1]=keyboard, [2]=audio, [3]=spare; asynchronous
- port_id  in  8  micro port address
- in_data  in  8  micro out_port data
- write_strobe  in  1  micro write strobe, 1 cycle
- read_strobe  in  1  micro read strobe, 1 cycle
- out_data  out  8  read data to micro input mux; 0 when port_id is not one of ours
- interrupt  out  1  to KCPSM6 interrupt
- interrupt_ack  in  1  from KCPSM6, 1-cycle pulse

Behaviour:
- Async reset:
  - sync flops, prev, pending, overrun and mask = 0.
  - out_data = 0, interrupt = 0, FSM = IDLE.
  - Reset mid-handshake abandons the handshake; no pending state survives.
- Input conditioning, per source:
  - 2-flop synchronizer, then XOR with POL_LOW[i] to normalize to active-high.
  - A rising edge of the normalized signal (cur & ~prev) is the event.
  - Pin edge to pending bit set: 3 clk.
- Pending:
  - Event sets pending[i].
  - A write to PORT_CLR clears pending[i] and overrun[i] for each in_data[i]=1.
  - Event and clear of the same bit in the same cycle: set wins; overrun is unchanged by that event.
- Overrun: an event on a bit that is already pending (and not being cleared that cycle) sets overrun[i]. Sticky; cleared only via PORT_CLR.
- Mask:
  - Write to PORT_MASK loads mask <= in_data[3:0].
  - active = pending & mask.
- Reads:
  - out_data is registered every cycle from the port_id decode, independent of read_strobe.
  - PORT_MASK returns {4'b0, mask}.
  - PORT_PEND returns {|active, 1'b0, idx[1:0], pending[3:0]}, where idx is the lowest-numbered set bit of active (0 if none).
  - PORT_OVR returns {4'b0, overrun}.
  - Any other port returns 8'h00.
  - Data is valid 1 clk after port_id; the KCPSM6 holds port_id 2 cycles on INPUT, so this meets timing.
  - Reads have no side effects.
- FSM (IDLE, ASSERT, SERVICE):
  - IDLE: interrupt=0. If |active, go to ASSERT next cycle.
  - ASSERT: interrupt=1. Held regardless of later mask or clear changes until interrupt_ack=1, then go to SERVICE. interrupt drops the cycle after ack.
  - SERVICE: interrupt=0. Wait for any write_strobe to PORT_CLR, then go to IDLE. A new event during SERVICE only sets pending.
  - After IDLE, if still |active, re-assert 1 cycle later; minimum low gap is 2 clk.
  - interrupt_ack outside ASSERT is ignored.
  - Write to PORT_CLR outside SERVICE: clears bits only, no state change.
- Latency:
  - Pin edge to interrupt=1 is 4 clk with the mask already set.
  - A mask write that enables an already-pending bit gives interrupt=1 2 clk after write_strobe.
- Simultaneous writes: only one port_id is valid per cycle, so no conflicts are possible. An unknown port_id with write_strobe is ignored.

Test Plan:
- Reset, mask=4'h2, keyboard pulse 0→1 (3 clk wide) -> pending=4'h2, interrupt=1 at 4 clk; read PORT_PEND = 8'h92; ack -> interrupt=0 next clk; write PORT_CLR=8'h02 -> pending=0, FSM IDLE, interrupt stays 0.
- mask=4'h1, RTC irq driven 1→0 -> pending[0]=1, interrupt=1; drive the pin back high -> no new event; RTC 0→1 edge alone never sets pending.
- mask=0, audio and spare both edge -> pending=4'hC, interrupt=0; write mask=8'h08 -> interrupt=1 2 clk later; PORT_PEND = 8'hBC (idx=3).
- Two keyboard edges with no clear -> overrun=4'h2 via PORT_OVR; an edge coincident with a PORT_CLR=8'h02 write -> pending[1]=1, overrun=0.
- Ack, then a new keyboard edge during SERVICE -> interrupt stays 0; PORT_CLR=8'h01 -> IDLE -> interrupt=1 again 1 clk later, since pending[1] is still set.
- Assert reset while interrupt=1 -> interrupt, pending, mask, out_data = 0 immediately (asynchronous); after release, a stray interrupt_ack has no effect.
